// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: shared register bank with a round-robin write arbiter.
// One write is committed per clock; the winner gets a one-cycle grant pulse.
// Optional burst locking is compiled in with `define REG_ARB_LOCK_EN.
module reg_bank_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          lock,
    input  logic [N_REQ*ADDR_W-1:0]   wr_addr,
    input  logic [N_REQ*DATA_W-1:0]   wr_data,
    output logic [N_REQ-1:0]          gnt,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [DATA_W-1:0] bank [DEPTH];
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  rr_next;
    logic [N_REQ-1:0]  gnt_next;
    logic              busy_next;
    logic [N_REQ-1:0]  elig;
    logic              found;
    logic [PTR_W-1:0]  win;
    logic              arb_en;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    int unsigned       idx;
    int unsigned       base_a;
    int unsigned       base_d;

`ifdef REG_ARB_LOCK_EN
    localparam int unsigned CNT_W = 4;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] owner_next;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cnt_next;
`else
    logic lock_unused;
    assign lock_unused = ^lock;
`endif

    // Control registers: grant, busy, round-robin pointer (and lock state).
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt    <= '0;
            busy   <= 1'b0;
            rr_ptr <= '0;
`ifdef REG_ARB_LOCK_EN
            state     <= ARB;
            owner     <= '0;
            burst_cnt <= '0;
`endif
        end else begin
            gnt    <= gnt_next;
            busy   <= busy_next;
            rr_ptr <= rr_next;
`ifdef REG_ARB_LOCK_EN
            state     <= state_next;
            owner     <= owner_next;
            burst_cnt <= cnt_next;
`endif
        end
    end

    // Next-state: pick the write for this edge and the follow-on control state.
    always_comb begin
        gnt_next  = '0;
        busy_next = 1'b0;
        rr_next   = rr_ptr;
        we        = 1'b0;
        waddr     = '0;
        wdata     = '0;
        found     = 1'b0;
        win       = '0;
        idx       = 0;
        base_a    = 0;
        base_d    = 0;
        arb_en    = 1'b1;
        // A requester holding req through its grant cycle is not re-served.
        elig      = req & ~gnt;
`ifdef REG_ARB_LOCK_EN
        state_next = state;
        owner_next = owner;
        cnt_next   = burst_cnt;
        if (state == LOCKED) begin
            if (req[owner] && lock[owner] && (burst_cnt < CNT_W'(MAX_BURST))) begin
                arb_en    = 1'b0;
                base_a    = 32'(owner) * ADDR_W;
                base_d    = 32'(owner) * DATA_W;
                we        = 1'b1;
                waddr     = wr_addr[base_a +: ADDR_W];
                wdata     = wr_data[base_d +: DATA_W];
                gnt_next  = N_REQ'(1) << owner;
                busy_next = 1'b1;
                cnt_next  = burst_cnt + CNT_W'(1);
            end else begin
                // Leaving the burst: arbitrate normally with the old owner masked.
                state_next = ARB;
                cnt_next   = '0;
                elig       = elig & ~(N_REQ'(1) << owner);
            end
        end
`endif
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % N_REQ;
            if (!found && elig[PTR_W'(idx)]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        if (arb_en && found) begin
            base_a    = 32'(win) * ADDR_W;
            base_d    = 32'(win) * DATA_W;
            we        = 1'b1;
            waddr     = wr_addr[base_a +: ADDR_W];
            wdata     = wr_data[base_d +: DATA_W];
            gnt_next  = N_REQ'(1) << win;
            busy_next = 1'b1;
            rr_next   = PTR_W'((32'(win) + 1) % N_REQ);
`ifdef REG_ARB_LOCK_EN
            if (lock[win]) begin
                state_next = LOCKED;
                owner_next = win;
                cnt_next   = CNT_W'(1);
            end
`endif
        end
    end

    // Storage words; reset clears the whole bank and suppresses any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                bank[i] <= '0;
            end
        end else if (we) begin
            bank[waddr] <= wdata;
        end
    end

    assign rd_data = bank[rd_addr];

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter (N_REQ=4, DATA_W=8, ADDR_W=3).
module tb_reg_bank_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  gnt;
    logic [2:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        busy;

    int vectors;
    int miscompares;

    reg_bank_arbiter #(
        .N_REQ(4), .DATA_W(8), .ADDR_W(3), .MAX_BURST(4)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .wr_addr(wr_addr), .wr_data(wr_data), .gnt(gnt),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int i, input logic [2:0] a, input logic [7:0] d);
        wr_addr[i*3 +: 3] = a;
        wr_data[i*8 +: 8] = d;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    logic [3:0] exp_lock [5];

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; req = '0; lock = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        // Single requester 2 held: grant, masked, grant.
        set_wr(2, 3'd5, 8'hA5);
        req = 4'b0100;
        tick();
        chk("single_gnt1", 32'(gnt), 32'h4);
        chk("single_busy1", 32'(busy), 32'h1);
        rd_chk("single_rd5", 3'd5, 8'hA5);
        tick();
        chk("single_gnt_masked", 32'(gnt), 32'h0);
        chk("single_busy_masked", 32'(busy), 32'h0);
        tick();
        chk("single_gnt2", 32'(gnt), 32'h4);
        req = 4'b0000;
        tick();
        chk("idle_gnt", 32'(gnt), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // Wrap: rr_ptr is 3 after granting 2.
        set_wr(0, 3'd0, 8'h10);
        set_wr(3, 3'd3, 8'h13);
        req = 4'b1001;
        tick();
        chk("wrap_gnt3", 32'(gnt), 32'h8);
        rd_chk("wrap_rd3", 3'd3, 8'h13);
        tick();
        chk("wrap_gnt0", 32'(gnt), 32'h1);
        rd_chk("wrap_rd0", 3'd0, 8'h10);

        // Reset with all requesting: nothing written, everything cleared.
        set_wr(0, 3'd1, 8'hFF);
        set_wr(1, 3'd1, 8'hFF);
        set_wr(2, 3'd1, 8'hFF);
        set_wr(3, 3'd1, 8'hFF);
        req = 4'b1111;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0000;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        for (int a = 0; a < 8; a++) begin
            rd_chk("rst_word", 3'(a), 8'h00);
        end

        // Same-address race from rr_ptr=0: 1 then 3, last write wins.
        set_wr(1, 3'd2, 8'h11);
        set_wr(3, 3'd2, 8'h33);
        req = 4'b1010;
        tick();
        chk("race_gnt1", 32'(gnt), 32'h2);
        rd_chk("race_rd_first", 3'd2, 8'h11);
        tick();
        req = 4'b0000;
        chk("race_gnt3", 32'(gnt), 32'h8);
        rd_chk("race_rd_final", 3'd2, 8'h33);
        tick();

        // Full contention from rr_ptr=0: strict rotation.
        for (int i = 0; i < 4; i++) set_wr(i, 3'(4 + i), 8'(8'hC0 + i));
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("full_gnt", 32'(gnt), 32'(4'b0001 << (c % 4)));
            chk("full_busy", 32'(busy), 32'h1);
        end
        req = 4'b0000;
        tick();
        for (int i = 0; i < 4; i++) rd_chk("full_word", 3'(4 + i), 8'(8'hC0 + i));

        // Requester 0 asks for a burst lock while everyone requests.
`ifdef REG_ARB_LOCK_EN
        exp_lock[0] = 4'b0001; exp_lock[1] = 4'b0001; exp_lock[2] = 4'b0001;
        exp_lock[3] = 4'b0001; exp_lock[4] = 4'b0010;
`else
        exp_lock[0] = 4'b0001; exp_lock[1] = 4'b0010; exp_lock[2] = 4'b0100;
        exp_lock[3] = 4'b1000; exp_lock[4] = 4'b0001;
`endif
        lock = 4'b0001;
        req  = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("lock_gnt", 32'(gnt), 32'(exp_lock[c]));
        end
        lock = 4'b0000;
        req  = 4'b0000;
        tick();
        chk("final_gnt", 32'(gnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Shared register bank of D-type storage words with a round-robin write arbiter in front of it. Up to N_REQ requesters each present an address/data write request; the block grants one write per cycle, commits it to the bank on the same clock edge, and acknowledges the winner with a one-cycle grant pulse. A combinational read port exposes any word. The block sits between multiple control agents and the flip-flop storage they share.

## Interface
- N_REQ, 4: number of requesters (2..8)
- DATA_W, 8: bits per register word
- ADDR_W, 3: address width; bank depth is 2^ADDR_W words
- MAX_BURST, 4: maximum consecutive locked writes per owner (1..15); used only with REG_ARB_LOCK_EN
- clk  input  1  rising-edge clock, sole clock
- rst  input  1  synchronous, active-high reset
- req  input  N_REQ  write request per requester
- lock  input  N_REQ  burst-lock request per requester (ignored unless REG_ARB_LOCK_EN)
- wr_addr  input  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- wr_data  input  N_REQ*DATA_W  packed data; requester i at [i*DATA_W +: DATA_W]
- gnt  output  N_REQ  registered one-hot grant pulse; at most one bit high
- rd_addr  input  ADDR_W  read address
- rd_data  output  DATA_W  combinational read of word rd_addr
- busy  output  1  registered; high when a write was committed on the last edge

## Operation
- Reset (rst=1 at a rising edge): all bank words <= 0, gnt <= 0, busy <= 0, rr_ptr <= 0, state <= ARB, burst_cnt <= 0. rst has priority over every request.
- Eligible set: elig[i] = req[i] & ~gnt[i] (a requester whose grant is high this cycle is masked, so a held req cannot double-write). Exception: the lock owner in LOCKED.
- State ARB: if elig is nonzero, winner w = first eligible index scanning rr_ptr, rr_ptr+1, ... mod N_REQ. At the edge: bank[wr_addr[w]] <= wr_data[w]; gnt <= one-hot(w); busy <= 1; rr_ptr <= (w+1) mod N_REQ. If elig is zero: gnt <= 0, busy <= 0, no write, rr_ptr unchanged.
- State LOCKED (REG_ARB_LOCK_EN only): see Configuration.
- Requester protocol: hold req, wr_addr, wr_data stable until gnt[i] is seen high; req still high during the gnt cycle is ignored that cycle and treated as a new request afterwards.
- Write collisions impossible: one write per cycle by construction. Multiple requesters targeting the same address commit in grant order; last write wins.
- rd_data reflects bank contents combinationally; no read/write bypass.

## Timing
- Request sampled at edge E; write committed and gnt asserted at edge E; both visible in the cycle after E. rd_data shows new value from the cycle after E.
- Single requester, req held: writes on alternate cycles (grant, masked, grant, ...).
- All N_REQ requesting continuously: one write per cycle, each requester granted once per N_REQ cycles; max wait N_REQ-1 cycles.
- rst asserted mid-burst or mid-grant: next edge clears everything; no write from any request on that edge.
- rr_ptr wrap: index N_REQ-1 wins -> rr_ptr = 0.

## Configuration
- REG_ARB_LOCK_EN defined: in ARB, if winner w has lock[w]=1, state -> LOCKED, owner <= w, burst_cnt <= 1. In LOCKED, only the owner is eligible (gnt mask not applied to it); each edge with req[owner]&lock[owner] and burst_cnt < MAX_BURST writes and increments burst_cnt. Exit to ARB (rr_ptr = owner+1 mod N_REQ, unchanged from entry) when req or lock of owner drops, or burst_cnt = MAX_BURST; on the exiting edge ARB arbitration applies normally with the owner masked.
- REG_ARB_LOCK_EN undefined: lock port present but ignored; no LOCKED state, no burst counter logic.

## Test plan
- Reset: write nonzero words, assert rst one cycle with req=4'b1111 -> all words read 0, gnt=0, busy=0, no write on that edge.
- Single requester: req=4'b0100, wr_addr[2]=5, data 8'hA5 -> cycle after: gnt=4'b0100, rd_data(5)=8'hA5; held req gives grants every other cycle.
- Full contention: req=4'b1111 for 8 cycles, distinct addresses -> gnt sequence 0001,0010,0100,1000,0001,... and all four words written.
- Same-address race: requesters 1 and 3 both write address 2 (8'h11, 8'h33), rr_ptr=0 -> gnt 0010 then 1000; final rd_data(2)=8'h33.
- Wrap: rr_ptr=3 after granting 2, req=4'b1001 -> grant 1000, then 0001.
- With REG_ARB_LOCK_EN, MAX_BURST=4: requester 0 req+lock held, others requesting -> gnt[0] four consecutive cycles, then requester 1 granted; without macro same stimulus -> round-robin only.
